fb_fill_engine: RTL and testbench
=================================

# fb_fill_engine

Hardware rectangle-fill engine for the framebuffer. It sits upstream of the dual-port data memory's CPU-side write port. Given a base address, rectangle size, row stride and 8-bit colour, it writes one pixel per clock into video memory, which the VGA controller then scans out through the memory's VGA read port. It offloads screen clears and solid-box drawing from the CPU.

## Interface
Parameters:
- DIM_W, 10, width of rectangle width/height/stride fields (max 1023)
- ADDR_W, 32, memory address width

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  terminates an in-progress fill
- base_addr  in  ADDR_W  byte address of top-left pixel
- rect_w  in  DIM_W  rectangle width in pixels
- rect_h  in  DIM_W  rectangle height in rows
- stride  in  DIM_W  address distance between rows (640 for full screen)
- color  in  8  pixel value
- busy  out  1  high while in FILL or DONE
- done  out  1  one-cycle pulse on normal completion
- mem_addr  out  ADDR_W  address to the memory's CPU port (cpu_addr)
- mem_wren  out  1  write enable to the memory's CPU port (cpu_wren)
- mem_data  out  32  write data (data_cpu) = {24'b0, color}

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE, start=1, abort=0: latch base_addr, rect_w, rect_h, stride and color. Clear the x and y counters and set row_addr = base_addr.
  - If rect_w==0 or rect_h==0, go to DONE; no writes occur.
  - Otherwise go to FILL.
- FILL: each cycle drive mem_wren=1, mem_addr=row_addr+x and mem_data={24'b0,color_q}. Pixels are written in raster order, x fastest.
  - When x==w_q-1: x←0, y←y+1, row_addr←row_addr+stride_q. The address is built with an accumulator; there is no multiplier.
  - On the last pixel (x==w_q-1 and y==h_q-1), go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort=1 in FILL: the write driven in that cycle still occurs. Go to IDLE with no done pulse. Any remaining pixels are discarded.
- abort=1 in IDLE or DONE: no effect, except that abort with start in IDLE suppresses start.
- start while busy is ignored. Latched parameters are unaffected by input changes after acceptance.
- Address arithmetic is modulo 2^ADDR_W; wrap past 0xFFFFFFFF is silent.
- stride < rect_w is legal; overlapping writes occur in the same raster order.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, mem_wren=0, mem_addr=0, mem_data=0. State=IDLE and all counters=0.
- start accepted at edge E0; first write presented in cycle following E0 (cycle 1).
- W*H consecutive write cycles with no gaps, in cycles 1..W*H. done is asserted in cycle W*H+1 and busy drops in cycle W*H+2.
- Zero-size rectangle: done in cycle 1, mem_wren stays 0.
- mem_wren is 0 in every cycle not in FILL. mem_addr and mem_data hold their last values when idle.
- Reset asserted mid-fill: outputs go to reset values immediately (asynchronous). No further writes and no done. After release, the engine is in IDLE.
- The memory write port is assumed always ready; there is no backpressure.

## Test plan
- Reset: assert reset mid-fill after 5 writes → mem_wren, busy and done go to 0 at once. After release, a new start works normally.
- 3x2 fill, base 0x100, stride 640, color 0x3C:
  - Writes at 0x100, 0x101, 0x102, 0x380, 0x381, 0x382 in cycles 1-6, each with data 0x0000003C.
  - done in cycle 7; busy is low from cycle 8.
- rect_w=0, rect_h=5 → no mem_wren, done pulse in cycle 1.
- Abort:
  - 4x4 fill at base 0.
  - Assert abort in the cycle writing address 1 → exactly 2 writes (0, 1), no done, busy low next cycle.
  - A subsequent start is accepted.
- start pulsed again during a 2x2 fill with different params → ignored: 4 writes with the original colour/addresses, a single done.
- 1x1 fill at base 0xFFFFFFFF → one write at 0xFFFFFFFF. Then a 2x1 fill at 0xFFFFFFFF writes 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: solid-rectangle fill into the framebuffer's CPU write port.
// One pixel per clock in raster order (x fastest). Row addresses come from an
// accumulator that adds the stride at each row wrap, so no multiplier is used.
// All outputs are registered. The next-cycle output values are computed
// combinationally and then loaded into the output registers together with
// the state, so the first write appears in the cycle right after start.
module fb_fill_engine #(
    parameter int DIM_W  = 10,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  rect_w,
    input  logic [DIM_W-1:0]  rect_h,
    input  logic [DIM_W-1:0]  stride,
    input  logic [7:0]        color,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [31:0]       mem_data,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    // Latched job parameters and raster position of the pixel presented now.
    logic [DIM_W-1:0]  r_w, r_h, r_stride;
    logic [7:0]        r_color;
    logic [DIM_W-1:0]  r_x, r_y;
    logic [ADDR_W-1:0] r_row;

    logic [DIM_W-1:0]  w_w_nxt, w_h_nxt, w_stride_nxt;
    logic [7:0]        w_color_nxt;
    logic [DIM_W-1:0]  w_x_nxt, w_y_nxt;
    logic [ADDR_W-1:0] w_row_nxt;

    // Registered output images.
    logic              r_busy, r_done, r_wren;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_data;

    logic              w_busy_nxt, w_done_nxt, w_wren_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       w_data_nxt;

    logic              w_x_last, w_y_last;
    logic [DIM_W-1:0]  w_x_inc;
    logic [ADDR_W-1:0] w_row_stepped;

    assign w_x_last      = (r_x == r_w - 1'b1);
    assign w_y_last      = (r_y == r_h - 1'b1);
    assign w_x_inc       = r_x + 1'b1;
    assign w_row_stepped = r_row + ADDR_W'(r_stride);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state, counter and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_w_nxt      = r_w;
        w_h_nxt      = r_h;
        w_stride_nxt = r_stride;
        w_color_nxt  = r_color;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_row_nxt    = r_row;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_wren_nxt   = 1'b0;
        w_addr_nxt   = r_mem_addr;
        w_data_nxt   = r_mem_data;
        case (r_state)
            S_IDLE: begin
                // abort together with start suppresses the request
                if (start && !abort) begin
                    w_w_nxt      = rect_w;
                    w_h_nxt      = rect_h;
                    w_stride_nxt = stride;
                    w_color_nxt  = color;
                    w_x_nxt      = '0;
                    w_y_nxt      = '0;
                    w_row_nxt    = base_addr;
                    w_busy_nxt   = 1'b1;
                    if (rect_w == '0 || rect_h == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_FILL;
                        w_wren_nxt  = 1'b1;
                        w_addr_nxt  = base_addr;
                        w_data_nxt  = {24'b0, color};
                    end
                end
            end
            S_FILL: begin
                if (abort) begin
                    // the write shown this cycle completes; the rest is dropped
                    w_state_nxt = S_IDLE;
                end else if (w_x_last && w_y_last) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_wren_nxt = 1'b1;
                    if (w_x_last) begin
                        w_x_nxt    = '0;
                        w_y_nxt    = r_y + 1'b1;
                        w_row_nxt  = w_row_stepped;
                        w_addr_nxt = w_row_stepped;
                    end else begin
                        w_x_nxt    = w_x_inc;
                        w_addr_nxt = r_row + ADDR_W'(w_x_inc);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Parameter latches, raster counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w        <= '0;
            r_h        <= '0;
            r_stride   <= '0;
            r_color    <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_row      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wren     <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_w        <= w_w_nxt;
            r_h        <= w_h_nxt;
            r_stride   <= w_stride_nxt;
            r_color    <= w_color_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_row      <= w_row_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_wren     <= w_wren_nxt;
            r_mem_addr <= w_addr_nxt;
            r_mem_data <= w_data_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_wren  = r_wren;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fb_fill_engine.sv
// Directed + randomized bench for fb_fill_engine. Expected write addresses are
// computed as base + y*stride + x (mod 2^32) and queued in raster order.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fb_fill_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] base_addr;
    logic [9:0]  rect_w, rect_h, stride;
    logic [7:0]  color;
    logic        busy, done, mem_wren;
    logic [31:0] mem_addr, mem_data;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    fb_fill_engine #(.DIM_W(10), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .rect_w    (rect_w),
        .rect_h    (rect_h),
        .stride    (stride),
        .color     (color),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_wren  (mem_wren),
        .mem_data  (mem_data),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // scramble parameter inputs so latching is exercised
    task automatic scramble();
        base_addr = $urandom;
        rect_w    = 10'($urandom);
        rect_h    = 10'($urandom);
        stride    = 10'($urandom);
        color     = 8'($urandom);
    endtask

    // Launch one fill and check every cycle up to two cycles past the end.
    // abort_at: index of the write during which abort is raised (-1 = none).
    // restart: pulse start with other parameters in the first write cycle.
    task automatic run_fill(input logic [31:0] b, input int w, input int h,
                            input int s, input logic [7:0] c,
                            input int abort_at, input bit restart);
        int n, nw;
        bit aborted;
        logic [31:0] last_a;
        exp_q.delete();
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                exp_q.push_back(b + 32'(y * s) + 32'(x));
        n       = w * h;
        aborted = (abort_at >= 0) && (abort_at < n);
        nw      = aborted ? abort_at + 1 : n;
        last_a  = '0;

        @(negedge clk);
        base_addr = b; rect_w = 10'(w); rect_h = 10'(h); stride = 10'(s); color = c;
        start = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        scramble();
        for (int k = 1; k <= nw; k++) begin
            start = (restart && k == 1);
            chk("wren", 32'(mem_wren), 32'd1);
            chk("addr", mem_addr, exp_q[0]);
            last_a = exp_q.pop_front();
            chk("data", mem_data, {24'b0, c});
            chk("busy_fill", 32'(busy), 32'd1);
            chk("done_fill", 32'(done), 32'd0);
            if (aborted && k == abort_at + 1) abort = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        if (aborted) begin
            chk("abort_wren", 32'(mem_wren), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_hold", mem_addr, last_a);
            @(negedge clk);
            chk("abort_idle", 32'(busy | done | mem_wren), 32'd0);
        end else begin
            chk("end_wren", 32'(mem_wren), 32'd0);
            chk("end_done", 32'(done), 32'd1);
            chk("end_busy", 32'(busy), 32'd1);
            @(negedge clk);
            chk("post_done", 32'(done), 32'd0);
            chk("post_busy", 32'(busy), 32'd0);
            chk("post_wren", 32'(mem_wren), 32'd0);
            if (nw > 0) chk("addr_hold", mem_addr, last_a);
        end
    endtask

    initial begin
        // reset block
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; rect_w = '0; rect_h = '0; stride = '0; color = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_data", mem_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 3x2 directed fill
        run_fill(32'h100, 3, 2, 640, 8'h3C, -1, 1'b0);

        // zero width: done in cycle 1, no writes
        run_fill(32'h200, 0, 5, 640, 8'h11, -1, 1'b0);

        // abort during the write to address 1, then a new start
        run_fill(32'h0, 4, 4, 4, 8'hA5, 1, 1'b0);
        run_fill(32'h10, 2, 1, 8, 8'h5A, -1, 1'b0);

        // start during a 2x2 fill is ignored
        run_fill(32'h400, 2, 2, 100, 8'h77, -1, 1'b1);

        // start together with abort in idle is suppressed
        @(negedge clk);
        base_addr = 32'h500; rect_w = 10'd2; rect_h = 10'd2; stride = 10'd4;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sup_busy", 32'(busy), 32'd0);
        chk("sup_wren", 32'(mem_wren), 32'd0);

        // address wrap
        run_fill(32'hFFFF_FFFF, 1, 1, 10, 8'h01, -1, 1'b0);
        run_fill(32'hFFFF_FFFF, 2, 1, 10, 8'h02, -1, 1'b0);

        // stride smaller than width (overlapping rows)
        run_fill(32'h1000, 4, 3, 2, 8'hC3, -1, 1'b0);

        // reset mid-fill after 5 writes
        @(negedge clk);
        base_addr = 32'h40; rect_w = 10'd4; rect_h = 10'd4; stride = 10'd16; color = 8'h99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk("pre_rst_wren", 32'(mem_wren), 32'd1);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        chk("arst_wren", 32'(mem_wren), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy | done | mem_wren), 32'd0);
        run_fill(32'h80, 3, 3, 5, 8'h42, -1, 1'b0);

        // randomized fills, some aborted
        for (int t = 0; t < 8; t++) begin
            int w, h, ab;
            w  = $urandom_range(0, 5);
            h  = $urandom_range(0, 4);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
            run_fill($urandom, w, h, $urandom_range(0, 1023), 8'($urandom), ab, 1'($urandom_range(0, 1)));
        end

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
